// File: rtl/usb_dev_rx.sv
// usb_dev_rx: device-side USB low/full-speed packet receiver.
// Samples DP/DM once per clock, matches SYNC, NRZI-decodes, drops stuffed
// bits, assembles LSB-first bytes and closes the packet on EOP with a
// sticky status word {se1, stuff, align, eop}.
module usb_dev_rx #(
    parameter logic [6:0] MAX_BYTES = 7'd127
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       dp,
    input  logic       dm,
    input  logic       rx_en,
    output logic       pkt_start,
    output logic       byte_valid,
    output logic [7:0] byte_out,
    output logic       pkt_end,
    output logic       pkt_ok,
    output logic [3:0] err,
    output logic [6:0] byte_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SYNC = 2'd1,
        ST_DATA = 2'd2,
        ST_EOP  = 2'd3
    } state_t;

    // Bit positions inside the error word
    localparam int ERR_SE1   = 3;
    localparam int ERR_STUFF = 2;
    localparam int ERR_ALIGN = 1;
    localparam int ERR_EOP   = 0;

    // Saturating increment used by the per-packet byte counter
    function automatic logic [6:0] sat_inc7(input logic [6:0] v, input logic [6:0] lim);
        logic [6:0] r;
        if (v >= lim) begin
            r = lim;
        end else begin
            r = v + 7'd1;
        end
        return r;
    endfunction

    // SYNC pattern K J K J K J K K: K on odd positions and on the last one
    function automatic logic sync_expect_k(input logic [3:0] idx);
        return idx[0] | (idx == 4'd8);
    endfunction

    // ------------------------------------------------------------------
    // State and output registers
    // ------------------------------------------------------------------
    state_t     state_q;
    logic       prev_k_q;      // previous decoded bus level, 1 = K, 0 = J
    logic [3:0] sync_idx_q;    // number of SYNC samples matched so far
    logic [2:0] ones_cnt_q;    // consecutive decoded 1s for destuffing
    logic [2:0] bit_cnt_q;     // data bits shifted into the current byte
    logic [7:0] shreg_q;
    logic [1:0] se0_cnt_q;     // SE0 samples seen in EOP, saturating at 3
    logic [3:0] err_q;
    logic [6:0] byte_cnt_q;
    logic [7:0] byte_out_q;
    logic       pkt_start_q;
    logic       byte_valid_q;
    logic       pkt_end_q;
    logic       pkt_ok_q;

    // ------------------------------------------------------------------
    // Combinational decode of the current sample
    // ------------------------------------------------------------------
    logic       is_j;
    logic       is_k;
    logic       is_se0;
    logic       is_se1;
    logic       rx_bit;
    logic       sync_match;
    logic [3:0] sync_idx_d;
    logic [7:0] shreg_d;
    logic [2:0] ones_cnt_d;
    logic       eop_bad;
    logic [3:0] err_end_d;

    // Line-state decode, NRZI bit recovery and next-value helpers
    always_comb begin
        is_j       = dp & ~dm;
        is_k       = ~dp & dm;
        is_se0     = ~dp & ~dm;
        is_se1     = dp & dm;
        // SE1 inside data is flagged but decoded as a J level (is_k = 0)
        rx_bit     = (is_k == prev_k_q);
        sync_idx_d = sync_idx_q + 4'd1;
        if (sync_expect_k(sync_idx_d)) begin
            sync_match = is_k;
        end else begin
            sync_match = is_j;
        end
        shreg_d    = {rx_bit, shreg_q[7:1]};
        if (rx_bit) begin
            ones_cnt_d = ones_cnt_q + 3'd1;
        end else begin
            ones_cnt_d = 3'd0;
        end
        // Only exactly two SE0 followed by J is a clean EOP
        eop_bad    = ~is_j | (se0_cnt_q != 2'd2);
        err_end_d  = err_q | {3'b000, eop_bad};
    end

    // Receiver FSM: SYNC match, destuffing, byte assembly, EOP and status pulses
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            prev_k_q     <= 1'b0;
            sync_idx_q   <= 4'd0;
            ones_cnt_q   <= 3'd0;
            bit_cnt_q    <= 3'd0;
            shreg_q      <= 8'd0;
            se0_cnt_q    <= 2'd0;
            err_q        <= 4'd0;
            byte_cnt_q   <= 7'd0;
            byte_out_q   <= 8'd0;
            pkt_start_q  <= 1'b0;
            byte_valid_q <= 1'b0;
            pkt_end_q    <= 1'b0;
            pkt_ok_q     <= 1'b0;
        end else begin
            // Pulses default low; each branch raises the one it needs
            pkt_start_q  <= 1'b0;
            byte_valid_q <= 1'b0;
            pkt_end_q    <= 1'b0;
            pkt_ok_q     <= 1'b0;
            if (!rx_en) begin
                // Abort: drop any partial byte, keep err/byte_cnt for inspection
                state_q   <= ST_IDLE;
                bit_cnt_q <= 3'd0;
                shreg_q   <= 8'd0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (is_k) begin
                            state_q    <= ST_SYNC;
                            sync_idx_q <= 4'd1;
                        end else begin
                            state_q    <= ST_IDLE;
                        end
                    end
                    ST_SYNC: begin
                        if (!sync_match) begin
                            state_q <= ST_IDLE;
                        end else if (sync_idx_d == 4'd8) begin
                            state_q     <= ST_DATA;
                            err_q       <= 4'd0;
                            byte_cnt_q  <= 7'd0;
                            bit_cnt_q   <= 3'd0;
                            shreg_q     <= 8'd0;
                            prev_k_q    <= 1'b1;
                            // The trailing SYNC 1 already counts toward stuffing
                            ones_cnt_q  <= 3'd1;
                            pkt_start_q <= 1'b1;
                        end else begin
                            sync_idx_q <= sync_idx_d;
                        end
                    end
                    ST_DATA: begin
                        if (is_se0) begin
                            state_q   <= ST_EOP;
                            se0_cnt_q <= 2'd1;
                            if (bit_cnt_q != 3'd0) begin
                                err_q[ERR_ALIGN] <= 1'b1;
                            end else begin
                                err_q[ERR_ALIGN] <= err_q[ERR_ALIGN];
                            end
                            bit_cnt_q <= 3'd0;
                        end else begin
                            if (is_se1) begin
                                err_q[ERR_SE1] <= 1'b1;
                            end else begin
                                err_q[ERR_SE1] <= err_q[ERR_SE1];
                            end
                            prev_k_q <= is_k;
                            if (ones_cnt_q == 3'd6) begin
                                // Stuff slot: must be a transition (0), never shifted in
                                ones_cnt_q <= 3'd0;
                                if (rx_bit) begin
                                    err_q[ERR_STUFF] <= 1'b1;
                                end else begin
                                    err_q[ERR_STUFF] <= err_q[ERR_STUFF];
                                end
                            end else begin
                                shreg_q    <= shreg_d;
                                ones_cnt_q <= ones_cnt_d;
                                if (bit_cnt_q == 3'd7) begin
                                    byte_out_q   <= shreg_d;
                                    byte_valid_q <= 1'b1;
                                    bit_cnt_q    <= 3'd0;
                                    byte_cnt_q   <= sat_inc7(byte_cnt_q, MAX_BYTES);
                                end else begin
                                    bit_cnt_q <= bit_cnt_q + 3'd1;
                                end
                            end
                        end
                    end
                    ST_EOP: begin
                        if (is_se0) begin
                            if (se0_cnt_q == 2'd3) begin
                                err_q[ERR_EOP] <= 1'b1;
                            end else begin
                                se0_cnt_q <= se0_cnt_q + 2'd1;
                                // Reaching a third SE0 already makes the EOP too long
                                if (se0_cnt_q == 2'd2) begin
                                    err_q[ERR_EOP] <= 1'b1;
                                end else begin
                                    err_q[ERR_EOP] <= err_q[ERR_EOP];
                                end
                            end
                        end else begin
                            err_q     <= err_end_d;
                            pkt_end_q <= 1'b1;
                            pkt_ok_q  <= (err_end_d == 4'd0);
                            state_q   <= ST_IDLE;
                        end
                    end
                    default: begin
                        state_q <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign pkt_start  = pkt_start_q;
    assign byte_valid = byte_valid_q;
    assign byte_out   = byte_out_q;
    assign pkt_end    = pkt_end_q;
    assign pkt_ok     = pkt_ok_q;
    assign err        = err_q;
    assign byte_cnt   = byte_cnt_q;

endmodule

// File: tb/tb_usb_dev_rx.sv
// Self-checking bench for usb_dev_rx: builds bus streams from byte payloads
// (NRZI + bit stuffing encoder) and predicts the receiver's report from the
// packet's construction (payload, injected faults, EOP shape).
module tb_usb_dev_rx;

    localparam logic [1:0] S_J   = 2'b10;
    localparam logic [1:0] S_K   = 2'b01;
    localparam logic [1:0] S_SE0 = 2'b00;
    localparam logic [1:0] S_SE1 = 2'b11;

    logic       clk = 1'b0;
    logic       rst;
    logic       dp;
    logic       dm;
    logic       rx_en;
    logic       pkt_start;
    logic       byte_valid;
    logic [7:0] byte_out;
    logic       pkt_end;
    logic       pkt_ok;
    logic [3:0] err;
    logic [6:0] byte_cnt;

    usb_dev_rx dut (
        .clk        (clk),
        .rst        (rst),
        .dp         (dp),
        .dm         (dm),
        .rx_en      (rx_en),
        .pkt_start  (pkt_start),
        .byte_valid (byte_valid),
        .byte_out   (byte_out),
        .pkt_end    (pkt_end),
        .pkt_ok     (pkt_ok),
        .err        (err),
        .byte_cnt   (byte_cnt)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Monitor (sole writer of these): collects the output stream mid-cycle
    logic [7:0] got_bytes[$];
    int         n_start   = 0;
    int         n_end     = 0;
    int         n_overlap = 0;
    logic [3:0] end_err   = 4'd0;
    logic       end_ok    = 1'b0;
    logic [6:0] end_cnt   = 7'd0;

    always @(negedge clk) begin
        if (byte_valid) got_bytes.push_back(byte_out);
        if (pkt_start) n_start++;
        if (pkt_end) begin
            n_end++;
            end_err = err;
            end_ok  = pkt_ok;
            end_cnt = byte_cnt;
        end
        if (byte_valid && pkt_end) n_overlap++;
    end

    // Stimulus state used by the initial process only
    logic [1:0] tx_q[$];
    logic [7:0] pay_q[$];
    bit         stuff_hit;
    int         s0, e0, b0;

    task automatic drive(input logic [1:0] s);
        dp = s[1];
        dm = s[0];
        @(posedge clk);
        #1;
    endtask

    task automatic mark();
        s0 = n_start;
        e0 = n_end;
        b0 = got_bytes.size();
    endtask

    task automatic send_tx();
        foreach (tx_q[i]) drive(tx_q[i]);
        repeat (3) drive(S_J);
    endtask

    // SYNC, then pay_q LSB-first plus extra_n bits, NRZI-encoded with stuffing.
    // bad_stuff sends the first stuff slot as a 1 (no transition).
    task automatic encode(input int extra_n, input logic [7:0] extra_v, input bit bad_stuff);
        logic [1:0] lvl;
        int         ones;
        bit         bad_left;
        bit         bits[$];
        tx_q.delete();
        for (int i = 0; i < 8; i++) tx_q.push_back((i == 7 || (i % 2) == 0) ? S_K : S_J);
        foreach (pay_q[i]) for (int b = 0; b < 8; b++) bits.push_back(pay_q[i][b]);
        for (int b = 0; b < extra_n; b++) bits.push_back(extra_v[b]);
        lvl       = S_K;
        ones      = 1;
        bad_left  = bad_stuff;
        stuff_hit = 1'b0;
        for (int i = 0; i <= bits.size(); i++) begin
            if (ones == 6) begin
                if (bad_left) begin
                    bad_left  = 1'b0;
                    stuff_hit = 1'b1;
                end else begin
                    lvl = (lvl == S_K) ? S_J : S_K;
                end
                tx_q.push_back(lvl);
                ones = 0;
            end
            if (i < bits.size()) begin
                if (bits[i]) begin
                    ones++;
                end else begin
                    ones = 0;
                    lvl  = (lvl == S_K) ? S_J : S_K;
                end
                tx_q.push_back(lvl);
            end
        end
    endtask

    task automatic add_eop(input int n_se0, input logic [1:0] term);
        repeat (n_se0) tx_q.push_back(S_SE0);
        tx_q.push_back(term);
    endtask

    // Replace the first J-level data sample at or after 'from' by SE1
    task automatic inject_se1(input int from, output bit done);
        done = 1'b0;
        for (int i = from; i < tx_q.size(); i++) begin
            if (!done && tx_q[i] == S_J) begin
                tx_q[i] = S_SE1;
                done    = 1'b1;
            end
        end
    endtask

    task automatic test_reset();
        rst   = 1'b1;
        rx_en = 1'b0;
        drive(S_J);
        drive(S_J);
        n_vec++;
        if ({pkt_start, byte_valid, byte_out, pkt_end, pkt_ok, err, byte_cnt} !== 23'd0) begin
            n_err++;
            $display("FAIL reset_outputs got %h want 0", {pkt_start, byte_valid, byte_out, pkt_end, pkt_ok, err, byte_cnt});
        end
        rst   = 1'b0;
        rx_en = 1'b1;
        repeat (2) drive(S_J);
    endtask

    task automatic test_ack();
        pay_q = '{8'hD2};
        encode(0, 8'h00, 1'b0);
        add_eop(2, S_J);
        mark();
        foreach (tx_q[i]) begin
            drive(tx_q[i]);
            if (i == 6) begin
                n_vec++;
                if (pkt_start !== 1'b0) begin n_err++; $display("FAIL ack_start_early got %b want 0", pkt_start); end
            end
            if (i == 7) begin
                n_vec++;
                if (pkt_start !== 1'b1) begin n_err++; $display("FAIL ack_start_timing got %b want 1", pkt_start); end
            end
            if (i == 15) begin
                n_vec++;
                if ({byte_valid, byte_out} !== {1'b1, 8'hD2}) begin
                    n_err++; $display("FAIL ack_byte got valid=%b byte=%h want valid=1 byte=d2", byte_valid, byte_out);
                end
            end
            if (i == 18) begin
                n_vec++;
                if ({pkt_end, pkt_ok, err, byte_cnt} !== {1'b1, 1'b1, 4'd0, 7'd1}) begin
                    n_err++; $display("FAIL ack_end got end=%b ok=%b err=%b cnt=%0d want end=1 ok=1 err=0000 cnt=1", pkt_end, pkt_ok, err, byte_cnt);
                end
            end
        end
        repeat (3) drive(S_J);
        n_vec++;
        if (n_start - s0 !== 1 || n_end - e0 !== 1 || got_bytes.size() - b0 !== 1) begin
            n_err++; $display("FAIL ack_counts got start=%0d end=%0d bytes=%0d want 1 1 1", n_start - s0, n_end - e0, got_bytes.size() - b0);
        end
    endtask

    task automatic test_stuffing();
        for (int bad = 0; bad < 2; bad++) begin
            pay_q = '{8'h3F, 8'h00};
            encode(0, 8'h00, bad != 0);
            add_eop(2, S_J);
            mark();
            send_tx();
            n_vec++;
            if (got_bytes.size() - b0 !== 2) begin
                n_err++; $display("FAIL stuff_nbytes bad=%0d got %0d want 2", bad, got_bytes.size() - b0);
            end else begin
                n_vec++;
                if (got_bytes[b0] !== 8'h3F || got_bytes[b0+1] !== 8'h00) begin
                    n_err++; $display("FAIL stuff_bytes bad=%0d got %h %h want 3f 00", bad, got_bytes[b0], got_bytes[b0+1]);
                end
            end
            n_vec++;
            if ({end_err, end_ok, end_cnt} !== {(bad != 0) ? 4'b0100 : 4'b0000, bad == 0, 7'd2}) begin
                n_err++; $display("FAIL stuff_status bad=%0d got err=%b ok=%b cnt=%0d", bad, end_err, end_ok, end_cnt);
            end
        end
    endtask

    task automatic test_bad_sync();
        mark();
        drive(S_K); drive(S_J); drive(S_K); drive(S_K);
        repeat (6) drive(S_J);
        n_vec++;
        if (n_start - s0 !== 0 || n_end - e0 !== 0) begin
            n_err++; $display("FAIL badsync_pulses got start=%0d end=%0d want 0 0", n_start - s0, n_end - e0);
        end
        pay_q = '{8'hD2};
        encode(0, 8'h00, 1'b0);
        add_eop(2, S_J);
        mark();
        send_tx();
        n_vec++;
        if (n_start - s0 !== 1 || got_bytes.size() - b0 !== 1 || end_ok !== 1'b1 || end_cnt !== 7'd1) begin
            n_err++; $display("FAIL badsync_ack got start=%0d bytes=%0d ok=%b cnt=%0d", n_start - s0, got_bytes.size() - b0, end_ok, end_cnt);
        end else begin
            n_vec++;
            if (got_bytes[b0] !== 8'hD2) begin n_err++; $display("FAIL badsync_ack_byte got %h want d2", got_bytes[b0]); end
        end
    endtask

    task automatic test_misaligned();
        pay_q = '{8'hD2};
        encode(3, 8'($urandom), 1'b0);
        add_eop(2, S_J);
        mark();
        send_tx();
        n_vec++;
        if (got_bytes.size() - b0 !== 1 || end_err !== 4'b0010 || end_ok !== 1'b0 || end_cnt !== 7'd1) begin
            n_err++; $display("FAIL misalign got bytes=%0d err=%b ok=%b cnt=%0d want 1 0010 0 1", got_bytes.size() - b0, end_err, end_ok, end_cnt);
        end else begin
            n_vec++;
            if (got_bytes[b0] !== 8'hD2) begin n_err++; $display("FAIL misalign_byte got %h want d2", got_bytes[b0]); end
        end
    endtask

    task automatic test_eop_faults();
        bit done;
        pay_q = '{8'hD2};
        encode(0, 8'h00, 1'b0);
        add_eop(1, S_J);
        mark();
        send_tx();
        n_vec++;
        if (n_end - e0 !== 1 || end_err !== 4'b0001 || end_ok !== 1'b0) begin
            n_err++; $display("FAIL eop_short got end=%0d err=%b ok=%b want 1 0001 0", n_end - e0, end_err, end_ok);
        end
        encode(0, 8'h00, 1'b0);
        inject_se1(12, done);
        add_eop(2, S_J);
        mark();
        send_tx();
        n_vec++;
        if (!done || end_err !== 4'b1000 || end_ok !== 1'b0 || got_bytes.size() - b0 !== 1) begin
            n_err++; $display("FAIL eop_se1 got injected=%b err=%b ok=%b bytes=%0d want 1 1000 0 1", done, end_err, end_ok, got_bytes.size() - b0);
        end else begin
            n_vec++;
            if (got_bytes[b0] !== 8'hD2) begin n_err++; $display("FAIL eop_se1_byte got %h want d2", got_bytes[b0]); end
        end
    endtask

    task automatic test_abort();
        pay_q = '{8'hD2, 8'hA5};
        encode(0, 8'h00, 1'b0);
        mark();
        for (int i = 0; i < 20; i++) drive(tx_q[i]);
        rx_en = 1'b0;
        drive(tx_q[20]);
        n_vec++;
        if ({pkt_end, byte_cnt, err} !== {1'b0, 7'd1, 4'd0}) begin
            n_err++; $display("FAIL abort_hold got end=%b cnt=%0d err=%b want 0 1 0000", pkt_end, byte_cnt, err);
        end
        rx_en = 1'b1;
        repeat (4) drive(S_J);
        n_vec++;
        if (n_end - e0 !== 0 || got_bytes.size() - b0 !== 1) begin
            n_err++; $display("FAIL abort_pulses got end=%0d bytes=%0d want 0 1", n_end - e0, got_bytes.size() - b0);
        end
        drive(S_K); drive(S_J); drive(S_K);
        rst = 1'b1;
        drive(S_J);
        n_vec++;
        if ({pkt_start, byte_valid, byte_out, pkt_end, pkt_ok, err, byte_cnt} !== 23'd0) begin
            n_err++; $display("FAIL midsync_reset got %h want 0", {pkt_start, byte_valid, byte_out, pkt_end, pkt_ok, err, byte_cnt});
        end
        rst = 1'b0;
        drive(S_J);
        pay_q = '{8'hD2};
        encode(0, 8'h00, 1'b0);
        add_eop(2, S_J);
        mark();
        send_tx();
        n_vec++;
        if (n_end - e0 !== 1 || got_bytes.size() - b0 !== 1 || end_ok !== 1'b1 || end_cnt !== 7'd1) begin
            n_err++; $display("FAIL after_reset_ack got end=%0d bytes=%0d ok=%b cnt=%0d", n_end - e0, got_bytes.size() - b0, end_ok, end_cnt);
        end else begin
            n_vec++;
            if (got_bytes[b0] !== 8'hD2) begin n_err++; $display("FAIL after_reset_byte got %h want d2", got_bytes[b0]); end
        end
    endtask

    task automatic test_saturation();
        int nbad;
        pay_q.delete();
        for (int i = 0; i < 130; i++) pay_q.push_back(8'($urandom));
        encode(0, 8'h00, 1'b0);
        add_eop(2, S_J);
        mark();
        send_tx();
        n_vec++;
        if (end_cnt !== 7'd127 || end_ok !== 1'b1 || got_bytes.size() - b0 !== 130) begin
            n_err++; $display("FAIL saturate got cnt=%0d ok=%b bytes=%0d want 127 1 130", end_cnt, end_ok, got_bytes.size() - b0);
        end else begin
            nbad = 0;
            for (int i = 0; i < 130; i++) if (got_bytes[b0+i] !== pay_q[i]) nbad++;
            n_vec++;
            if (nbad != 0) begin n_err++; $display("FAIL saturate_bytes got %0d wrong bytes want 0", nbad); end
        end
    endtask

    task automatic test_random();
        int         nb, kind, extra_n, n_se0, nbad;
        logic [1:0] term;
        bit         se1_done;
        logic [3:0] exp_err;
        logic [6:0] exp_cnt;
        for (int it = 0; it < 40; it++) begin
            nb   = int'($urandom_range(0, 5));
            kind = int'($urandom_range(0, 6));
            pay_q.delete();
            for (int i = 0; i < nb; i++) pay_q.push_back(8'($urandom));
            if (kind == 1) begin
                if (nb == 0) pay_q.push_back(8'hFF);
                else pay_q[0] = 8'hFF;
            end
            extra_n = (kind == 2) ? int'($urandom_range(1, 7)) : 0;
            encode(extra_n, 8'($urandom), kind == 1);
            se1_done = 1'b0;
            if (kind == 5) inject_se1(8, se1_done);
            n_se0 = 2;
            term  = S_J;
            if (kind == 3) n_se0 = 1;
            if (kind == 4) n_se0 = int'($urandom_range(3, 4));
            if (kind == 6) term = ($urandom_range(0, 1) != 0) ? S_K : S_SE1;
            add_eop(n_se0, term);
            exp_err = {se1_done, stuff_hit, (extra_n % 8) != 0, !(n_se0 == 2 && term == S_J)};
            exp_cnt = (pay_q.size() > 127) ? 7'd127 : 7'(pay_q.size());
            mark();
            send_tx();
            n_vec++;
            if (n_start - s0 !== 1 || n_end - e0 !== 1) begin
                n_err++; $display("FAIL rand%0d_pulses got start=%0d end=%0d want 1 1", it, n_start - s0, n_end - e0);
            end
            n_vec++;
            if (got_bytes.size() - b0 !== pay_q.size()) begin
                n_err++; $display("FAIL rand%0d_nbytes got %0d want %0d", it, got_bytes.size() - b0, pay_q.size());
            end else begin
                nbad = 0;
                foreach (pay_q[i]) if (got_bytes[b0+i] !== pay_q[i]) nbad++;
                n_vec++;
                if (nbad != 0) begin n_err++; $display("FAIL rand%0d_bytes got %0d wrong want 0", it, nbad); end
            end
            n_vec++;
            if (end_err !== exp_err || end_ok !== (exp_err == 4'd0) || end_cnt !== exp_cnt) begin
                n_err++; $display("FAIL rand%0d_status kind=%0d got err=%b ok=%b cnt=%0d want err=%b ok=%b cnt=%0d",
                                  it, kind, end_err, end_ok, end_cnt, exp_err, exp_err == 4'd0, exp_cnt);
            end
        end
        n_vec++;
        if (n_overlap !== 0) begin n_err++; $display("FAIL valid_end_overlap got %0d want 0", n_overlap); end
    endtask

    initial begin
        rst   = 1'b1;
        rx_en = 1'b0;
        dp    = 1'b1;
        dm    = 1'b0;
        test_reset();
        test_ack();
        test_stuffing();
        test_bad_sync();
        test_misaligned();
        test_eop_faults();
        test_abort();
        test_saturation();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
